// File: rtl/pipe_stage_ctrl.sv
// Pipeline-stage controller with a main + skid holding buffer.
// Handshake outputs come straight from registered state, so the two sides have no combinational path between them.
module pipe_stage_ctrl #(
  parameter int                DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RST_DATA = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic [1:0]          occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_LEN-1:0] main_data;
  logic [DATA_LEN-1:0] skid_data;

  logic in_fire;
  logic out_fire;
  logic main_load_in;
  logic main_load_skid;
  logic skid_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_d = TWO;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        TWO:     if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs depend only on the state register; load strobes also see the live handshake.
  always_comb begin
    out_valid      = 1'b0;
    in_ready       = 1'b1;
    occupancy      = 2'd0;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        occupancy = 2'd0;
      end
      ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      TWO: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        occupancy = 2'd2;
      end
      default: begin
        occupancy = 2'd0;
      end
    endcase
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    case (state_q)
      EMPTY:   main_load_in = in_fire;
      ONE: begin
        main_load_in = in_fire & out_fire;
        skid_load    = in_fire & ~out_fire;
      end
      TWO:     main_load_skid = out_fire;
      default: main_load_in = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= RST_DATA;
      skid_data <= RST_DATA;
    end else if (flush) begin
      main_data <= RST_DATA;
      skid_data <= RST_DATA;
    end else begin
      if (main_load_in) begin
        main_data <= in_data;
      end else if (main_load_skid) begin
        main_data <= skid_data;
      end
      if (skid_load) begin
        skid_data <= in_data;
      end
    end
  end

  assign out_data = main_data;

endmodule
